// File: rtl/alu_pkg.sv
// Shared definitions for the ARK ALU: operation encoding and datapath width.
package definitions;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    kADD = 2'b00,
    kSUB = 2'b01,
    kAND = 2'b10,
    kXOR = 2'b11
  } op_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath issue logic and the ALU.
interface alu_if
  import definitions::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  op_t              OP;
  logic [WIDTH-1:0] INPUTA;
  logic [WIDTH-1:0] INPUTB;
  logic [WIDTH-1:0] OUT;
  logic             ZERO;
  logic             EQUAL;

  modport master (
    output OP, INPUTA, INPUTB,
    input  OUT, ZERO, EQUAL
  );

  modport slave (
    input  OP, INPUTA, INPUTB,
    output OUT, ZERO, EQUAL
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational ALU core: result, zero flag and operand equality for one operation.
module alu_comb
  import definitions::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  op_t              OP,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             equal
);

  always_comb begin
    result = '0;
    unique case (OP)
      kADD: result = INPUTA + INPUTB;
      kSUB: result = INPUTA - INPUTB;
      kAND: result = INPUTA & INPUTB;
      kXOR: result = INPUTA ^ INPUTB;
      default: result = '0;
    endcase
  end

  // zero is taken from this cycle's result so it always pairs with the same OUT value
  assign zero  = (result == '0);
  assign equal = (INPUTA == INPUTB);

endmodule

// File: rtl/alu.sv
// Registered ALU: one clock of latency from operand sampling to OUT/ZERO/EQUAL.
module alu
  import definitions::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic   CLK,
  input  logic   RESET_N,
  alu_if.slave   bus
);

  logic [WIDTH-1:0] result;
  logic             zero;
  logic             equal;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .OP     (bus.OP),
    .INPUTA (bus.INPUTA),
    .INPUTB (bus.INPUTB),
    .result (result),
    .zero   (zero),
    .equal  (equal)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.OUT   <= '0;
      bus.ZERO  <= 1'b1;
      bus.EQUAL <= 1'b0;
    end else begin
      bus.OUT   <= result;
      bus.ZERO  <= zero;
      bus.EQUAL <= equal;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, randomized back-to-back ops, async reset.
module tb_alu;
  import definitions::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_if bus ();

  alu dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_out(input op_t op, input logic [15:0] a, input logic [15:0] b);
    int unsigned full;
    case (op)
      kADD: full = (int'(a) + int'(b)) % 65536;
      kSUB: full = (int'(a) - int'(b) + 65536) % 65536;
      kAND: full = int'(a & b);
      default: full = int'(a ^ b);
    endcase
    return full[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_zero, input logic e_eq);
    chk({tag, ".out"},   bus.OUT, e_out);
    chk({tag, ".zero"},  {15'd0, bus.ZERO}, {15'd0, e_zero});
    chk({tag, ".equal"}, {15'd0, bus.EQUAL}, {15'd0, e_eq});
  endtask

  // drive at the falling edge, let one rising edge sample, check at the next falling edge
  task automatic step(input string tag, input op_t op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] e;
    bus.OP = op;
    bus.INPUTA = a;
    bus.INPUTB = b;
    e = ref_out(op, a, b);
    @(negedge clk);
    chk_all(tag, e, e == 16'h0000, a == b);
  endtask

  initial begin
    op_t         rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] hold_out;
    logic        hold_zero;
    logic        hold_eq;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.OP = kADD;
    bus.INPUTA = 16'h0000;
    bus.INPUTB = 16'h0000;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.OP = op_t'(i);
      bus.INPUTA = 16'($urandom);
      bus.INPUTB = bus.INPUTA;
      @(negedge clk);
      chk_all("reset_hold", 16'h0000, 1'b1, 1'b0);
    end

    rst_n = 1'b1;
    step("add_4_4", kADD, 16'h0004, 16'h0004);
    chk_all("add_4_4_const", 16'h0008, 1'b0, 1'b1);
    step("sub_4_4", kSUB, 16'h0004, 16'h0004);
    chk_all("sub_4_4_const", 16'h0000, 1'b1, 1'b1);
    step("and_4_4", kAND, 16'h0004, 16'h0004);
    chk_all("and_4_4_const", 16'h0004, 1'b0, 1'b1);
    step("xor_4_3", kXOR, 16'h0004, 16'h0003);
    chk_all("xor_4_3_const", 16'h0007, 1'b0, 1'b0);

    hold_out = bus.OUT;
    hold_zero = bus.ZERO;
    hold_eq = bus.EQUAL;
    bus.OP = kSUB;
    bus.INPUTA = 16'h1234;
    bus.INPUTB = 16'h1234;
    #3;
    chk_all("no_comb_path", hold_out, hold_zero, hold_eq);
    @(negedge clk);
    chk_all("after_edge", 16'h0000, 1'b1, 1'b1);

    step("wrap_add", kADD, 16'hFFFF, 16'h0001);
    chk_all("wrap_add_const", 16'h0000, 1'b1, 1'b0);
    step("wrap_sub", kSUB, 16'h0000, 16'h0001);
    chk_all("wrap_sub_const", 16'hFFFF, 1'b0, 1'b0);
    step("wrap_8000", kADD, 16'h8000, 16'h8000);
    chk_all("wrap_8000_const", 16'h0000, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      rop = op_t'(i % 4);
      if (i % 8 == 0) rop = op_t'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      if (i % 11 == 0) rb = 16'h0000;
      step("rand", rop, ra, rb);
    end

    step("pre_reset", kXOR, 16'hA5A5, 16'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("reset_held", 16'h0000, 1'b1, 1'b0);
    rst_n = 1'b1;
    step("post_reset", kAND, 16'hF0F0, 16'hFF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit, four-function ALU for the ARK processor datapath.
- Computes ADD/SUB/AND/XOR on two 16-bit operands.
- Flags a zero result and operand equality.
- Result and flags are registered: one clock of latency, feeding the writeback/branch logic.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below is stated for 16.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- OP  input  2  operation select, type op_t from package definitions.
- INPUTA  input  16  operand A.
- INPUTB  input  16  operand B.
- OUT  output  16  registered result.
- ZERO  output  1  registered; 1 when the result loaded into OUT is 16'h0000.
- EQUAL  output  1  registered; 1 when INPUTA == INPUTB at the sampling edge.

Behaviour:
- One clock; reset is asynchronous and active-low (RESET_N).
- Reset: while RESET_N=0, OUT=16'h0000, ZERO=1, EQUAL=0.
  - Reset takes effect immediately, independent of CLK.
  - First update after release is at the first rising CLK edge with RESET_N=1.
- Operation encoding (definitions::op_t):
  - kADD=2'b00: OUT = INPUTA + INPUTB, modulo 2^16; carry discarded.
  - kSUB=2'b01: OUT = INPUTA - INPUTB, two's complement modulo 2^16; borrow discarded.
  - kAND=2'b10: OUT = INPUTA & INPUTB, bitwise.
  - kXOR=2'b11: OUT = INPUTA ^ INPUTB, bitwise.
- All four codes are legal; there is no illegal-op case.
- Latency:
  - Inputs are sampled at rising CLK; OUT/ZERO/EQUAL reflect them after that edge and hold until the next edge.
  - Throughput is one operation per cycle; there is no handshake or enable.
- ZERO is computed from the same-cycle combinational result, not from the previous OUT, so ZERO and OUT always refer to the same operation.
- EQUAL:
  - Compares the raw operands and is independent of OP.
  - For kSUB, EQUAL=1 implies ZERO=1.
- Wrap-around:
  - 16'hFFFF + 16'h0001 gives OUT=16'h0000, ZERO=1.
  - 16'h0000 - 16'h0001 gives OUT=16'hFFFF, ZERO=0.
- Inputs changing mid-cycle have no effect until the next rising edge; no combinational path from inputs to outputs.
- Reset asserted mid-stream forces the reset values at once; the operation in progress is lost.
- X/unknown inputs are not sanitised; the bench drives known values only.

Decomposition:
- Package definitions (shared with decoder and bench):
  - typedef enum logic [1:0] op_t {kADD, kSUB, kAND, kXOR}, with the encodings above.
  - Localparam for data width 16.
- Optional sub-module alu_comb:
  - Purely combinational; inputs OP, INPUTA, INPUTB; outputs result, zero, equal.
  - alu wraps it with the output register and async reset.
  - Keeps the combinational function reusable and unit-testable.

Test Plan:
- Reset check: hold RESET_N=0, toggle inputs and clock -> OUT=0000, ZERO=1, EQUAL=0 throughout. Release reset, then A=4, B=4, OP=kADD -> after one edge OUT=0008, ZERO=0, EQUAL=1.
- Basic ops: A=4, B=4, OP=kSUB -> OUT=0000, ZERO=1, EQUAL=1. Then OP=kAND -> OUT=0004, ZERO=0, EQUAL=1.
- XOR and equality: B=3, OP=kXOR -> OUT=0007, ZERO=0, EQUAL=0. Check outputs do not change before the clock edge.
- Wrap-around:
  - FFFF kADD 0001 -> OUT=0000, ZERO=1, EQUAL=0.
  - 0000 kSUB 0001 -> OUT=FFFF, ZERO=0.
  - 8000 kADD 8000 -> OUT=0000, ZERO=1, EQUAL=1.
- Back-to-back throughput: change OP/operands every cycle across all four ops -> each result appears exactly one cycle later. Then assert RESET_N low between edges -> outputs go to reset values immediately, without a clock edge.
